// File: rtl/memory_arbiter_pkg.sv
// Shared encodings and the control payload for the I/D memory arbiter.
package memory_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'b00;
  localparam logic [1:0] ARB_OWN_I   = 2'b01;
  localparam logic [1:0] ARB_OWN_D   = 2'b10;
  localparam logic [1:0] ARB_RELEASE = 2'b11;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_I    = 2'b01;
  localparam logic [1:0] OWNER_D    = 2'b10;

  typedef struct packed {
    logic enable;
    logic op_init;
    logic op;
    logic op_done;
  } mem_ctrl_t;

  // Owner code seen by the mux for a given arbiter state.
  function automatic logic [1:0] owner_of(input logic [1:0] st);
    case (st)
      ARB_OWN_I: owner_of = OWNER_I;
      ARB_OWN_D: owner_of = OWNER_D;
      default:   owner_of = OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_port_mux.sv
// 2:1 ownership mux toward Memory plus response gating back to each requester.
module arb_port_mux
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic [1:0]            owner,
  input  logic                  force_done,
  input  mem_ctrl_t             i_ctrl,
  input  mem_ctrl_t             d_ctrl,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] i_data_in,
  input  logic [LINE_WIDTH-1:0] d_data_in,
  input  logic [LINE_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_ready,
  input  logic                  memory_in_use,
  output mem_ctrl_t             mem_ctrl,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_data_in,
  output logic [LINE_WIDTH-1:0] i_data_out,
  output logic [LINE_WIDTH-1:0] d_data_out,
  output logic                  i_data_ready,
  output logic                  d_data_ready,
  output logic                  i_in_use,
  output logic                  d_in_use
);

  always_comb begin
    mem_ctrl     = '0;
    mem_address  = '0;
    mem_data_in  = '0;
    i_data_out   = '0;
    d_data_out   = '0;
    i_data_ready = 1'b0;
    d_data_ready = 1'b0;
    case (owner)
      OWNER_I: begin
        mem_ctrl     = i_ctrl;
        mem_address  = i_address;
        mem_data_in  = i_data_in;
        i_data_out   = mem_data_out;
        i_data_ready = mem_data_ready;
      end
      OWNER_D: begin
        mem_ctrl     = d_ctrl;
        mem_address  = d_address;
        mem_data_in  = d_data_in;
        d_data_out   = mem_data_out;
        d_data_ready = mem_data_ready;
      end
      default: ;
    endcase
    // Watchdog release closes the Memory transaction on the hung owner's behalf.
    mem_ctrl.op_done = mem_ctrl.op_done | (force_done && (owner != OWNER_NONE));
  end

  assign i_in_use = memory_in_use | (owner == OWNER_D);
  assign d_in_use = memory_in_use | (owner == OWNER_I);

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one Memory between the I and D cache miss paths.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned MAX_HOLD   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_mem_enable,
  input  logic                  i_mem_op_init,
  input  logic                  i_mem_op,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  input  logic [LINE_WIDTH-1:0] i_mem_data_in,
  input  logic                  i_mem_op_done,
  output logic [LINE_WIDTH-1:0] i_mem_data_out,
  output logic                  i_mem_data_ready,
  output logic                  i_memory_in_use,
  input  logic                  d_mem_enable,
  input  logic                  d_mem_op_init,
  input  logic                  d_mem_op,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [LINE_WIDTH-1:0] d_mem_data_in,
  input  logic                  d_mem_op_done,
  output logic [LINE_WIDTH-1:0] d_mem_data_out,
  output logic                  d_mem_data_ready,
  output logic                  d_memory_in_use,
  output logic                  mem_enable,
  output logic                  mem_op_init,
  output logic                  mem_op,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_data_in,
  output logic                  mem_op_done,
  input  logic [LINE_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_ready,
  input  logic                  memory_in_use,
  output logic [1:0]            owner,
  output logic                  timeout
);

  localparam int unsigned CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state, state_next;
  logic             last_grant_d, last_grant_d_next;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
  logic             own_enable, own_done;
  mem_ctrl_t        i_ctrl, d_ctrl, mem_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB_IDLE;
      last_grant_d <= 1'b1;
      hold_cnt     <= '0;
    end else begin
      state        <= state_next;
      last_grant_d <= last_grant_d_next;
      hold_cnt     <= hold_cnt_next;
    end
  end

  assign own_enable = (state == ARB_OWN_D) ? d_mem_enable  : i_mem_enable;
  assign own_done   = (state == ARB_OWN_D) ? d_mem_op_done : i_mem_op_done;

  // Grant, release and watchdog decisions.
  always_comb begin
    state_next        = state;
    last_grant_d_next = last_grant_d;
    hold_cnt_next     = hold_cnt;
    timeout           = 1'b0;
    case (state)
      ARB_IDLE: begin
        hold_cnt_next = '0;
        if (!memory_in_use) begin
          if (i_mem_enable && (!d_mem_enable || last_grant_d)) begin
            state_next        = ARB_OWN_I;
            last_grant_d_next = 1'b0;
          end else if (d_mem_enable) begin
            state_next        = ARB_OWN_D;
            last_grant_d_next = 1'b1;
          end
        end
      end
      ARB_OWN_I, ARB_OWN_D: begin
        if (!own_enable || own_done) begin
          state_next = ARB_RELEASE;
        end else if (hold_cnt == HOLD_LAST) begin
          timeout    = 1'b1;
          state_next = ARB_RELEASE;
        end else begin
          hold_cnt_next = hold_cnt + CNT_W'(1);
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  assign owner  = owner_of(state);
  assign i_ctrl = '{enable: i_mem_enable, op_init: i_mem_op_init, op: i_mem_op, op_done: i_mem_op_done};
  assign d_ctrl = '{enable: d_mem_enable, op_init: d_mem_op_init, op: d_mem_op, op_done: d_mem_op_done};

  arb_port_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LINE_WIDTH(LINE_WIDTH)
  ) u_mux (
    .owner          (owner),
    .force_done     (timeout),
    .i_ctrl         (i_ctrl),
    .d_ctrl         (d_ctrl),
    .i_address      (i_mem_address),
    .d_address      (d_mem_address),
    .i_data_in      (i_mem_data_in),
    .d_data_in      (d_mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_data_ready (mem_data_ready),
    .memory_in_use  (memory_in_use),
    .mem_ctrl       (mem_ctrl),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .i_data_out     (i_mem_data_out),
    .d_data_out     (d_mem_data_out),
    .i_data_ready   (i_mem_data_ready),
    .d_data_ready   (d_mem_data_ready),
    .i_in_use       (i_memory_in_use),
    .d_in_use       (d_memory_in_use)
  );

  assign mem_enable  = mem_ctrl.enable;
  assign mem_op_init = mem_ctrl.op_init;
  assign mem_op      = mem_ctrl.op;
  assign mem_op_done = mem_ctrl.op_done;

endmodule
